// File: rtl/operand_hold_ctrl_if.sv
// Bundle between the issue pipe and the operand hold scheduler: R-stage slot
// info and pipe controls in, per-side hold decisions, wrong-side flags and statistics out.
interface operand_hold_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             Enable;
  logic             MemStall_s1;
  logic             MipsMode_s2e;
  logic             AValid_s2r;
  logic             BValid_s2r;
  logic [31:0]      AInstr_s2r;
  logic [31:0]      BInstr_s2r;
  logic             CntClr;

  logic             AHold_s1e;
  logic             BHold_s1e;
  logic             AWrong_e;
  logic             AWrong_m;
  logic             AWrong_w;
  logic             BWrong_e;
  logic             BWrong_m;
  logic             BWrong_w;
  logic [CNT_W-1:0] AHoldCnt;
  logic [CNT_W-1:0] BHoldCnt;

  modport master (
    output Enable, MemStall_s1, MipsMode_s2e, AValid_s2r, BValid_s2r,
           AInstr_s2r, BInstr_s2r, CntClr,
    input  AHold_s1e, BHold_s1e, AWrong_e, AWrong_m, AWrong_w,
           BWrong_e, BWrong_m, BWrong_w, AHoldCnt, BHoldCnt
  );

  modport slave (
    input  Enable, MemStall_s1, MipsMode_s2e, AValid_s2r, BValid_s2r,
           AInstr_s2r, BInstr_s2r, CntClr,
    output AHold_s1e, BHold_s1e, AWrong_e, AWrong_m, AWrong_w,
           BWrong_e, BWrong_m, BWrong_w, AHoldCnt, BHoldCnt
  );
endinterface

// File: rtl/operand_hold_ctrl.sv
// Per-pipe scheduler deciding whether the A/B E-stage operand bus registers
// load or hold, with wrong-side flags tracked down E/M/W and saturating hold statistics.
module operand_hold_ctrl #(
  parameter int CNT_W  = 16,
  parameter int OPC_HI = 31
) (
  input logic                Phi1,
  input logic                ResetB_s1,
  operand_hold_ctrl_if.slave bus
);

  typedef enum logic {
    PASS = 1'b0,
    HOLD = 1'b1
  } hold_state_e;

  function automatic logic a_ignore(input logic [5:0] op, input logic [5:0] fn);
    return op[5] | (op[5:2] == 4'h4) | ((op == 6'd0) & (fn[5:2] == 4'h3));
  endfunction

  function automatic logic b_ignore(input logic [5:0] op, input logic [5:0] fn);
    return (op[5:2] == 4'h5) |
           ((op[5:3] == 3'd0) & (op[2:0] != 3'd0)) |
           ((op == 6'd0) & ((fn[5:3] == 3'd0) | (fn[5:4] == 2'b01) | (fn[5:2] == 4'h2)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                input logic clr, input logic inc);
    if (clr)      return '0;
    else if (inc) return sat_inc(cnt);
    else          return cnt;
  endfunction

  // Disabling suppression releases the busses at once, even under a stall.
  function automatic hold_state_e next_state(input hold_state_e st, input logic en,
                                             input logic adv, input logic wrong);
    if (!en)      return PASS;
    else if (adv) return wrong ? HOLD : PASS;
    else          return st;
  endfunction

  logic [5:0]       a_op, a_fn, b_op, b_fn;
  logic             advance;
  logic             a_wrong_r, b_wrong_r;
  logic [2:0]       a_pipe_d, a_pipe_q;
  logic [2:0]       b_pipe_d, b_pipe_q;
  hold_state_e      a_state_d, a_state_q;
  hold_state_e      b_state_d, b_state_q;
  logic [CNT_W-1:0] a_cnt_d, a_cnt_q;
  logic [CNT_W-1:0] b_cnt_d, b_cnt_q;

  // R stage: decode, with invalid slots masked so their instruction bits never matter
  always_comb begin
    a_op      = bus.AValid_s2r ? bus.AInstr_s2r[OPC_HI -: 6] : 6'd0;
    a_fn      = bus.AValid_s2r ? bus.AInstr_s2r[5:0]         : 6'd0;
    b_op      = bus.BValid_s2r ? bus.BInstr_s2r[OPC_HI -: 6] : 6'd0;
    b_fn      = bus.BValid_s2r ? bus.BInstr_s2r[5:0]         : 6'd0;
    advance   = ~bus.MemStall_s1;
    a_wrong_r = ~bus.AValid_s2r | a_ignore(a_op, a_fn);
    b_wrong_r = ~bus.BValid_s2r | b_ignore(b_op, b_fn) | (~a_wrong_r & bus.MipsMode_s2e);

    a_pipe_d  = advance ? {a_pipe_q[1:0], a_wrong_r} : a_pipe_q;
    b_pipe_d  = advance ? {b_pipe_q[1:0], b_wrong_r} : b_pipe_q;
    a_state_d = next_state(a_state_q, bus.Enable, advance, a_wrong_r);
    b_state_d = next_state(b_state_q, bus.Enable, advance, b_wrong_r);
    a_cnt_d   = next_cnt(a_cnt_q, bus.CntClr,
                         bus.Enable & advance & (a_state_q == HOLD));
    b_cnt_d   = next_cnt(b_cnt_q, bus.CntClr,
                         bus.Enable & advance & (b_state_q == HOLD));
  end

  // R -> E boundary (wrong-side flags continue to M and W)
  always_ff @(posedge Phi1) begin
    if (!ResetB_s1) begin
      a_state_q <= PASS;
      b_state_q <= PASS;
      a_pipe_q  <= 3'b000;
      b_pipe_q  <= 3'b000;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
    end else begin
      a_state_q <= a_state_d;
      b_state_q <= b_state_d;
      a_pipe_q  <= a_pipe_d;
      b_pipe_q  <= b_pipe_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
    end
  end

  assign bus.AHold_s1e = (a_state_q == HOLD);
  assign bus.BHold_s1e = (b_state_q == HOLD);
  assign bus.AWrong_e  = a_pipe_q[0];
  assign bus.AWrong_m  = a_pipe_q[1];
  assign bus.AWrong_w  = a_pipe_q[2];
  assign bus.BWrong_e  = b_pipe_q[0];
  assign bus.BWrong_m  = b_pipe_q[1];
  assign bus.BWrong_w  = b_pipe_q[2];
  assign bus.AHoldCnt  = a_cnt_q;
  assign bus.BHoldCnt  = b_cnt_q;

endmodule
